interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 99 +++++++++
 tb/tb_interrupt_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - fixed-priority interrupt controller with CPU ack/done handshake
module interrupt_controller #(
   parameter int NUM_SRC = 4,
   parameter int VEC_W   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] int_request,
   input  logic [NUM_SRC-1:0] int_enable,
   input  logic               cpu_ack,
   input  logic               cpu_done,
   output logic               cpu_irq,
   output logic [VEC_W-1:0]   int_vector,
   output logic [NUM_SRC-1:0] int_handled,
   output logic               busy,
   output logic [7:0]         irq_count
);

   typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_SERVICE, S_CLEAR} state_t;

   state_t             r_state;
   logic [NUM_SRC-1:0] r_req_meta;
   logic [NUM_SRC-1:0] r_req_s;
   logic               r_irq;
   logic [VEC_W-1:0]   r_vec;
   logic [NUM_SRC-1:0] r_handled;
   logic [7:0]         r_count;

   logic [NUM_SRC-1:0] w_elig;
   logic [VEC_W-1:0]   w_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_meta <= '0;
         r_req_s    <= '0;
      end else begin
         r_req_meta <= int_request;
         r_req_s    <= r_req_meta;
      end
   end

   assign w_elig = r_req_s & int_enable;

   // Scan from the top down so the lowest set index is the last writer and wins.
   always_comb begin
      w_win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) w_win = VEC_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_irq     <= 1'b0;
         r_vec     <= '0;
         r_handled <= '0;
         r_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_elig) begin
                  r_state <= S_REQUEST;
                  r_vec   <= w_win;
                  r_irq   <= 1'b1;
               end
            end
            S_REQUEST: begin
               if (cpu_ack) begin
                  r_state <= S_SERVICE;
                  r_irq   <= 1'b0;
               end
            end
            S_SERVICE: begin
               if (cpu_done) begin
                  r_state   <= S_CLEAR;
                  r_handled <= NUM_SRC'(1) << r_vec;
               end
            end
            S_CLEAR: begin
               // Hold the acknowledge until the handler has withdrawn its request.
               if (!r_req_s[r_vec]) begin
                  r_state   <= S_IDLE;
                  r_handled <= '0;
                  r_count   <= r_count + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cpu_irq     = r_irq;
   assign int_vector  = r_vec;
   assign int_handled = r_handled;
   assign busy        = (r_state != S_IDLE);
   assign irq_count   = r_count;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and randomized checks of interrupt_controller against a transaction model
module tb_interrupt_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] int_request;
   logic [3:0] int_enable;
   logic       cpu_ack;
   logic       cpu_done;
   logic       cpu_irq;
   logic [1:0] int_vector;
   logic [3:0] int_handled;
   logic       busy;
   logic [7:0] irq_count;

   int n_tests = 0;
   int n_fail  = 0;
   int m_count = 0;

   interrupt_controller #(.NUM_SRC(4), .VEC_W(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .int_request (int_request),
      .int_enable  (int_enable),
      .cpu_ack     (cpu_ack),
      .cpu_done    (cpu_done),
      .cpu_irq     (cpu_irq),
      .int_vector  (int_vector),
      .int_handled (int_handled),
      .busy        (busy),
      .irq_count   (irq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Lowest-indexed set bit of the eligible set.
   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // From REQUEST: ack, done, then drop all requests and return to IDLE.
   task automatic finish_txn(input int vec);
      cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
      chk("ack_irq_low", cpu_irq, 0);
      cpu_done = 1'b1; step(); cpu_done = 1'b0;
      chk("done_handled", int_handled, 32'(1 << vec));
      int_request = 4'b0000;
      step(2);
      chk("clear_hold", int_handled, 32'(1 << vec));
      step();
      m_count = (m_count + 1) % 256;
      chk("clear_release", int_handled, 0);
      chk("clear_busy", busy, 0);
      chk("clear_count", irq_count, m_count);
   endtask

   initial begin
      int en, rq, vec, d;
      rst_n = 1'b0; int_request = '0; int_enable = '0; cpu_ack = 0; cpu_done = 0;
      #2;
      chk("rst_irq", cpu_irq, 0);
      chk("rst_vec", int_vector, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", irq_count, 0);
      step(2);
      rst_n = 1'b1;

      // Single source, latency of three edges
      int_enable = 4'b1111; int_request = 4'b0100;
      step(2);
      chk("lat_early", cpu_irq, 0);
      step();
      chk("lat_irq", cpu_irq, 1);
      chk("lat_vec", int_vector, 2);
      chk("lat_busy", busy, 1);
      finish_txn(2);

      // Priority, then re-arbitration of the still-pending source after one idle cycle
      int_request = 4'b1010;
      step(3);
      chk("prio_vec", int_vector, 1);
      cpu_ack = 1; step(); cpu_ack = 0;
      cpu_done = 1; step(); cpu_done = 0;
      int_request = 4'b1000;
      step(3);
      m_count++;
      chk("prio_idle_irq", cpu_irq, 0);
      chk("prio_count", irq_count, m_count);
      step();
      chk("rearb_irq", cpu_irq, 1);
      chk("rearb_vec", int_vector, 3);
      finish_txn(3);

      // Mask and no preemption
      int_enable = 4'b1110; int_request = 4'b0001;
      step(5);
      chk("mask_irq", cpu_irq, 0);
      chk("mask_busy", busy, 0);
      int_request = 4'b0101;
      step(3);
      chk("nopre_vec0", int_vector, 2);
      int_request = 4'b0111; int_enable = 4'b1111;
      step(4);
      chk("nopre_irq", cpu_irq, 1);
      chk("nopre_vec", int_vector, 2);
      finish_txn(2);

      // Simultaneous ack and done: only the ack takes effect
      int_request = 4'b0001;
      step(3);
      chk("sim_irq", cpu_irq, 1);
      cpu_ack = 1; cpu_done = 1; step(); cpu_ack = 0; cpu_done = 0;
      chk("sim_irq_low", cpu_irq, 0);
      chk("sim_handled", int_handled, 0);
      chk("sim_busy", busy, 1);
      step(2);
      chk("sim_handled_hold", int_handled, 0);
      cpu_done = 1; step(); cpu_done = 0;
      chk("sim_done", int_handled, 4'b0001);

      // Reset mid-CLEAR is immediate and aborts the transaction
      step();
      chk("clr_before_rst", int_handled, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("arst_handled", int_handled, 0);
      chk("arst_busy", busy, 0);
      chk("arst_count", irq_count, 0);
      chk("arst_irq", cpu_irq, 0);
      m_count = 0;
      step();
      rst_n = 1'b1;
      step(2);
      chk("post_rst_early", cpu_irq, 0);
      step();
      chk("post_rst_irq", cpu_irq, 1);
      chk("post_rst_vec", int_vector, 0);
      finish_txn(0);

      // Randomized transactions; enough of them to wrap irq_count
      for (int it = 0; it < 300; it++) begin
         en = $urandom_range(1, 15);
         do rq = $urandom_range(1, 15); while ((rq & en) == 0);
         vec = lowest(4'(rq & en));
         int_enable = 4'(en); int_request = 4'(rq);
         step(2);
         chk("rnd_early", cpu_irq, 0);
         step();
         chk("rnd_irq", cpu_irq, 1);
         chk("rnd_vec", int_vector, vec);
         d = $urandom_range(0, 3);
         for (int k = 0; k < d; k++) begin
            int_request = 4'($urandom_range(0, 15)) | 4'(1 << vec);
            int_enable  = 4'($urandom_range(0, 15));
            cpu_done    = 1'($urandom_range(0, 1));
            step();
            chk("rnd_req_hold_irq", cpu_irq, 1);
            chk("rnd_req_hold_vec", int_vector, vec);
         end
         cpu_ack = 1; cpu_done = 1'($urandom_range(0, 1)); step(); cpu_ack = 0; cpu_done = 0;
         chk("rnd_ack", cpu_irq, 0);
         chk("rnd_ack_handled", int_handled, 0);
         d = $urandom_range(0, 2);
         for (int k = 0; k < d; k++) begin
            cpu_ack = 1'($urandom_range(0, 1));
            step();
            chk("rnd_svc_handled", int_handled, 0);
         end
         cpu_ack = 0;
         cpu_done = 1; step(); cpu_done = 0;
         chk("rnd_done", int_handled, 32'(1 << vec));
         int_request = 4'b0000;
         step(2);
         chk("rnd_clear_hold", int_handled, 32'(1 << vec));
         step();
         m_count = (m_count + 1) % 256;
         chk("rnd_release", int_handled, 0);
         chk("rnd_busy", busy, 0);
         chk("rnd_count", irq_count, m_count);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
